// File: rtl/vram_write_buffer_pkg.sv
// Shared types for the VRAM posted-write buffer.
//   entry_t       : one queued write, {addr, data}
//   drain_state_t : background drain FSM states
//   fe_state_t    : requester front-end / read FSM states
//   BUS_W         : address and data width of both sides
package vram_wb_pkg;

  localparam int BUS_W = 32;

  typedef struct packed {
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    DR_IDLE,
    DR_FETCH,
    DR_WRITE,
    DR_GAP
  } drain_state_t;

  // FE_ACCEPT is the idle state of the front end; FE_RELEASE also serves
  // as the one-cycle gap after a read leaves the bus.
  typedef enum logic [1:0] {
    FE_ACCEPT,
    FE_RWAIT,
    FE_READ,
    FE_RELEASE
  } fe_state_t;

endpackage

// File: rtl/vram_write_buffer_dual_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
//   clock   : rising-edge clock
//   rd_addr : read address, data appears on rd_data one cycle later
//   rd_data : registered read data (read-before-write on collisions)
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data
// The storage array has no reset so it maps onto block RAM.
module dual_port_ram #(
  parameter int WIDTH = 64,
  parameter int SIZE  = 4096
) (
  input  logic                    clock,
  input  logic [$clog2(SIZE)-1:0] rd_addr,
  output logic [WIDTH-1:0]        rd_data,
  input  logic                    wr_en,
  input  logic [$clog2(SIZE)-1:0] wr_addr,
  input  logic [WIDTH-1:0]        wr_data
);

  logic [WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vram_write_buffer.sv
// Posted-write buffer between one requester and a slower VRAM bus.
// Writes are queued in a RAM FIFO and acknowledged at once; a drain FSM
// empties the FIFO onto the bus in order. Reads wait for an idle bus
// (and, with STALL_READ=1, an empty FIFO) and complete on bus ready.
//
// Ports:
//   i_clock, i_reset_n         : clock, synchronous active-low reset
//   o_empty, o_full            : registered FIFO status
//   o_bus_*/i_bus_*            : memory bus (request held until i_bus_ready)
//   i_request/i_rw/i_address/
//   i_wdata, o_ready, o_rdata  : requester side
//
// Handshake (both sides): the initiator raises request as a level and
// holds it, together with rw/address/wdata, until the responder returns a
// single-cycle ready pulse. Read data is valid only with that pulse. The
// requester must drop request before a new transaction is accepted.
module vram_write_buffer
  import vram_wb_pkg::*;
#(
  parameter int DEPTH      = 4096,
  parameter bit STALL_READ = 1'b0
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_bus_rw,
  output logic             o_bus_request,
  input  logic             i_bus_ready,
  output logic [BUS_W-1:0] o_bus_address,
  input  logic [BUS_W-1:0] i_bus_rdata,
  output logic [BUS_W-1:0] o_bus_wdata,
  input  logic             i_rw,
  input  logic             i_request,
  output logic             o_ready,
  input  logic [BUS_W-1:0] i_address,
  output logic [BUS_W-1:0] o_rdata,
  input  logic [BUS_W-1:0] i_wdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = (AW)'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  drain_state_t  drain_state;
  fe_state_t     fe_state;
  entry_t        head;
  entry_t        push_entry;
  logic          push;
  logic          pop;
  logic          read_pending;
  logic          drain_start;
  logic          read_start;

  assign push_entry = '{addr: i_address, data: i_wdata};

  // The read port always points at the head entry; by the time the drain
  // FSM reaches FETCH the head has been in the RAM for at least a cycle.
  dual_port_ram #(
    .WIDTH($bits(entry_t)),
    .SIZE (DEPTH)
  ) u_ram (
    .clock  (i_clock),
    .rd_addr(rd_ptr),
    .rd_data(head),
    .wr_en  (push),
    .wr_addr(wr_ptr),
    .wr_data(push_entry)
  );

  always_comb begin
    push = (fe_state == FE_ACCEPT) && i_request && i_rw && !o_full;
    pop  = (drain_state == DR_WRITE) && i_bus_ready;
    // A read counts as pending from the cycle it is first seen so that a
    // drain cannot slip onto the bus in the same cycle the read arrives.
    read_pending = (fe_state == FE_RWAIT) ||
                   ((fe_state == FE_ACCEPT) && i_request && !i_rw);
    // In coherent mode the read waits for the FIFO to empty, so it must
    // not hold off the drain or the two would deadlock.
    drain_start = (drain_state == DR_IDLE) && !o_empty &&
                  (fe_state != FE_READ) && (STALL_READ || !read_pending);
    read_start  = (fe_state == FE_RWAIT) && (drain_state == DR_IDLE) &&
                  (!STALL_READ || o_empty);
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count - CNT_ONE;
    end
  end

  // Both FSMs live in one block because they share the bus output
  // registers; drain_start/read_start guarantee a single bus owner.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      o_empty       <= 1'b1;
      o_full        <= 1'b0;
      o_bus_request <= 1'b0;
      o_bus_rw      <= 1'b0;
      o_bus_address <= '0;
      o_bus_wdata   <= '0;
      o_ready       <= 1'b0;
      o_rdata       <= '0;
      drain_state   <= DR_IDLE;
      fe_state      <= FE_ACCEPT;
    end else begin
      o_ready <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count   <= count_next;
      o_empty <= (count_next == '0);
      o_full  <= (count_next == FULL_COUNT);

      case (fe_state)
        FE_ACCEPT: begin
          if (push) begin
            o_ready  <= 1'b1;
            fe_state <= FE_RELEASE;
          end else if (i_request && !i_rw) begin
            fe_state <= FE_RWAIT;
          end
        end
        FE_RWAIT: begin
          if (read_start) begin
            o_bus_request <= 1'b1;
            o_bus_rw      <= 1'b0;
            o_bus_address <= i_address;
            fe_state      <= FE_READ;
          end
        end
        FE_READ: begin
          if (i_bus_ready) begin
            o_bus_request <= 1'b0;
            o_rdata       <= i_bus_rdata;
            o_ready       <= 1'b1;
            fe_state      <= FE_RELEASE;
          end
        end
        FE_RELEASE: begin
          if (!i_request) begin
            fe_state <= FE_ACCEPT;
          end
        end
        default: fe_state <= FE_ACCEPT;
      endcase

      case (drain_state)
        DR_IDLE: begin
          if (drain_start) begin
            drain_state <= DR_FETCH;
          end
        end
        DR_FETCH: begin
          o_bus_request <= 1'b1;
          o_bus_rw      <= 1'b1;
          o_bus_address <= head.addr;
          o_bus_wdata   <= head.data;
          drain_state   <= DR_WRITE;
        end
        DR_WRITE: begin
          if (i_bus_ready) begin
            o_bus_request <= 1'b0;
            drain_state   <= DR_GAP;
          end
        end
        DR_GAP: drain_state <= DR_IDLE;
        default: drain_state <= DR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_write_buffer.sv
// Bench for vram_write_buffer. Instance 0: DEPTH=4, STALL_READ=0.
// Instance 1: DEPTH=4096, STALL_READ=1. A bus responder answers each bus
// request after bus_delay[d] cycles (or never while bus_hold[d]) and
// checks every bus transaction against the expected queue exp_q.
module tb_vram_write_buffer;

  typedef struct {
    int          d;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    int          post;   // 0 none, 1 expect not empty, 2 wait for empty
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        req [2];
  logic        rw [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        bus_ready [2];
  logic [31:0] bus_rdata [2];
  logic        empty [2];
  logic        full [2];
  logic        bus_rw [2];
  logic        bus_req [2];
  logic        ready [2];
  logic [31:0] bus_addr [2];
  logic [31:0] bus_wdata [2];
  logic [31:0] rdata [2];
  logic        bus_hold [2];
  int          bus_delay [2];
  logic [31:0] rd_val [2];
  int          wait_cnt [2];
  logic [64:0] exp_q [$];
  int          total;
  int          bad;
  vec_t        tbl [11];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  vram_write_buffer #(.DEPTH(4), .STALL_READ(1'b0)) u_bypass (
    .i_clock(clk), .i_reset_n(rst_n), .o_empty(empty[0]), .o_full(full[0]),
    .o_bus_rw(bus_rw[0]), .o_bus_request(bus_req[0]), .i_bus_ready(bus_ready[0]),
    .o_bus_address(bus_addr[0]), .i_bus_rdata(bus_rdata[0]), .o_bus_wdata(bus_wdata[0]),
    .i_rw(rw[0]), .i_request(req[0]), .o_ready(ready[0]), .i_address(addr[0]),
    .o_rdata(rdata[0]), .i_wdata(wdata[0])
  );

  vram_write_buffer #(.DEPTH(4096), .STALL_READ(1'b1)) u_stall (
    .i_clock(clk), .i_reset_n(rst_n), .o_empty(empty[1]), .o_full(full[1]),
    .o_bus_rw(bus_rw[1]), .o_bus_request(bus_req[1]), .i_bus_ready(bus_ready[1]),
    .o_bus_address(bus_addr[1]), .i_bus_rdata(bus_rdata[1]), .o_bus_wdata(bus_wdata[1]),
    .i_rw(rw[1]), .i_request(req[1]), .o_ready(ready[1]), .i_address(addr[1]),
    .o_rdata(rdata[1]), .i_wdata(wdata[1])
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic r, input logic [31:0] a, input logic [31:0] dt);
    exp_q.push_back({r, a, r ? dt : 32'h0});
  endtask

  task automatic sb_check(input int g, input logic r, input logic [31:0] a, input logic [31:0] dt);
    logic [64:0] got;
    logic [64:0] e;
    got = {r, a, r ? dt : 32'h0};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL bus_txn_dut%0d actual=%h required=none", g, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        bad++;
        $display("FAIL bus_txn_dut%0d actual=%h required=%h", g, got, e);
      end
    end
  endtask

  // ---------------- bus responder ----------------
  initial begin
    for (int g = 0; g < 2; g++) begin
      bus_ready[g] = 1'b0;
      bus_rdata[g] = 32'h0;
      wait_cnt[g]  = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int g = 0; g < 2; g++) begin
        if (bus_ready[g]) begin
          bus_ready[g] = 1'b0;
        end else if (rst_n && bus_req[g] && !bus_hold[g]) begin
          if (wait_cnt[g] >= bus_delay[g]) begin
            wait_cnt[g]  = 0;
            bus_ready[g] = 1'b1;
            bus_rdata[g] = rd_val[g];
            sb_check(g, bus_rw[g], bus_addr[g], bus_wdata[g]);
          end else begin
            wait_cnt[g]++;
          end
        end else begin
          wait_cnt[g] = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] dt, output int lat);
    rw[d] = 1'b1; addr[d] = a; wdata[d] = dt; req[d] = 1'b1; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ready[d] && lat < 100);
    req[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input int d, input logic [31:0] a, output logic [31:0] got, output int lat);
    rw[d] = 1'b0; addr[d] = a; req[d] = 1'b1; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ready[d] && lat < 300);
    got = rdata[d];
    req[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_empty(input int d, input string name);
    int n;
    n = 0;
    while (!empty[d] && n < 500) begin @(posedge clk); #1; n++; end
    check(name, empty[d], 1'b1);
  endtask

  // Three queued writes followed by a read of 0x40; the caller has
  // already queued the bus order it expects.
  task automatic read_behind_writes(input int d, input string tag);
    int lat;
    logic [31:0] got;
    bus_delay[d] = 8;
    rd_val[d] = 32'hDEADBEEF;
    do_write(d, 32'h1000, 32'h5000, lat); check({tag, "_wack0"}, lat, 1);
    do_write(d, 32'h1004, 32'h5001, lat); check({tag, "_wack1"}, lat, 1);
    do_write(d, 32'h1008, 32'h5002, lat); check({tag, "_wack2"}, lat, 1);
    do_read(d, 32'h40, got, lat);
    check({tag, "_rack"}, ready[d] === 1'b0 && lat < 300, 1'b1);
    check({tag, "_rdata"}, got, 32'hDEADBEEF);
    wait_empty(d, {tag, "_drained"});
    check({tag, "_bus_order_left"}, exp_q.size(), 0);
  endtask

  // ---------------- test ----------------
  initial begin
    int lat;
    int n;
    int d;
    logic seen;
    logic [31:0] got;

    total = 0; bad = 0;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      req[g] = 1'b0; rw[g] = 1'b0; addr[g] = 32'h0; wdata[g] = 32'h0;
      bus_hold[g] = 1'b0; bus_delay[g] = 0; rd_val[g] = 32'h0;
    end

    tbl[0] = '{1, 1'b1, 32'h100, 32'hA5A5A5A5, 32'h0, 0, 2};
    tbl[1] = '{1, 1'b1, 32'h000, 32'hC0DE0000, 32'h0, 5, 1};
    tbl[2] = '{1, 1'b1, 32'h004, 32'hC0DE0004, 32'h0, 5, 1};
    tbl[3] = '{1, 1'b1, 32'h008, 32'hC0DE0008, 32'h0, 5, 1};
    tbl[4] = '{1, 1'b1, 32'h00C, 32'hC0DE000C, 32'h0, 5, 1};
    tbl[5] = '{1, 1'b1, 32'h010, 32'hC0DE0010, 32'h0, 5, 1};
    tbl[6] = '{1, 1'b1, 32'h014, 32'hC0DE0014, 32'h0, 5, 1};
    tbl[7] = '{1, 1'b1, 32'h018, 32'hC0DE0018, 32'h0, 5, 1};
    tbl[8] = '{1, 1'b1, 32'h01C, 32'hC0DE001C, 32'h0, 5, 1};
    tbl[9] = '{1, 1'b0, 32'h200, 32'h0, 32'h12345678, 2, 2};
    tbl[10] = '{0, 1'b0, 32'h300, 32'h0, 32'h0BADF00D, 0, 0};

    // reset state, sampled while reset is still asserted
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_empty%0d", g), empty[g], 1'b1);
      check($sformatf("rst_full%0d", g), full[g], 1'b0);
      check($sformatf("rst_bus_req%0d", g), bus_req[g], 1'b0);
      check($sformatf("rst_ready%0d", g), ready[g], 1'b0);
      check($sformatf("rst_rdata%0d", g), rdata[g], 32'h0);
      check($sformatf("rst_bus_rw%0d", g), bus_rw[g], 1'b0);
      check($sformatf("rst_bus_addr%0d", g), bus_addr[g], 32'h0);
      check($sformatf("rst_bus_wdata%0d", g), bus_wdata[g], 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // table-driven vectors
    for (int i = 0; i < 11; i++) begin
      d = tbl[i].d;
      bus_delay[d] = tbl[i].dly;
      rd_val[d] = tbl[i].rdata;
      exp_push(tbl[i].rw, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].rw) begin
        do_write(d, tbl[i].addr, tbl[i].wdata, lat);
        check($sformatf("vec%0d_write_ack_latency", i), lat, 1);
      end else begin
        do_read(d, tbl[i].addr, got, lat);
        check($sformatf("vec%0d_read_ack", i), lat < 300, 1'b1);
        check($sformatf("vec%0d_rdata", i), got, tbl[i].rdata);
      end
      if (tbl[i].post == 1) check($sformatf("vec%0d_not_empty", i), empty[d], 1'b0);
      if (tbl[i].post == 2) wait_empty(d, $sformatf("vec%0d_empty_again", i));
    end
    check("table_bus_left", exp_q.size(), 0);

    // coherent read waits for all three writes
    exp_push(1'b1, 32'h1000, 32'h5000);
    exp_push(1'b1, 32'h1004, 32'h5001);
    exp_push(1'b1, 32'h1008, 32'h5002);
    exp_push(1'b0, 32'h40, 32'h0);
    read_behind_writes(1, "stall1");

    // bypass read goes right after the in-flight write
    exp_push(1'b1, 32'h1000, 32'h5000);
    exp_push(1'b0, 32'h40, 32'h0);
    exp_push(1'b1, 32'h1004, 32'h5001);
    exp_push(1'b1, 32'h1008, 32'h5002);
    read_behind_writes(0, "stall0");

    // full FIFO (DEPTH=4): fifth write waits for a drain
    bus_hold[0] = 1'b1;
    bus_delay[0] = 0;
    for (int i = 0; i < 4; i++) begin
      exp_push(1'b1, 32'h2000 + 32'(4 * i), 32'h7000 + 32'(i));
      do_write(0, 32'h2000 + 32'(4 * i), 32'h7000 + 32'(i), lat);
      check($sformatf("fill%0d_ack_latency", i), lat, 1);
    end
    check("full_set", full[0], 1'b1);
    exp_push(1'b1, 32'h2010, 32'h7004);
    rw[0] = 1'b1; addr[0] = 32'h2010; wdata[0] = 32'h7004; req[0] = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ready[0]) seen = 1'b1;
    end
    check("full_no_ack", seen, 1'b0);
    check("full_held", full[0], 1'b1);
    bus_hold[0] = 1'b0;
    n = 0;
    while (!ready[0] && n < 40) begin @(posedge clk); #1; n++; end
    check("full_ack_after_drain", ready[0], 1'b1);
    req[0] = 1'b0;
    @(posedge clk); #1;
    wait_empty(0, "full_drained");
    check("full_bus_left", exp_q.size(), 0);

    // request held one extra cycle after ready: single push only
    bus_delay[0] = 2;
    exp_push(1'b1, 32'h2800, 32'h2828);
    rw[0] = 1'b1; addr[0] = 32'h2800; wdata[0] = 32'h2828; req[0] = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ready[0] && n < 100);
    check("hold_first_ack", ready[0], 1'b1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ready[0]) seen = 1'b1;
    end
    check("hold_no_second_ack", seen, 1'b0);
    wait_empty(0, "hold_drained");
    check("hold_bus_left", exp_q.size(), 0);

    // reset in the middle of a bus write abandons it
    bus_hold[0] = 1'b1;
    exp_push(1'b1, 32'h3000, 32'h3333);
    do_write(0, 32'h3000, 32'h3333, lat);
    n = 0;
    while (!bus_req[0] && n < 20) begin @(posedge clk); #1; n++; end
    check("midrst_bus_req_before", bus_req[0], 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_bus_req", bus_req[0], 1'b0);
    check("midrst_empty", empty[0], 1'b1);
    check("midrst_ready", ready[0], 1'b0);
    exp_q.delete();
    bus_hold[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_push(1'b1, 32'h3004, 32'h4444);
    do_write(0, 32'h3004, 32'h4444, lat);
    check("postrst_ack_latency", lat, 1);
    wait_empty(0, "postrst_drained");
    check("postrst_bus_left", exp_q.size(), 0);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_write_buffer.md
Name: vram_write_buffer

Overview:
- Posted-write buffer between a single requester (CPU/video controller) and a slower memory bus (VRAM port).
- Writes are queued in a block-RAM FIFO and acknowledged immediately; the FIFO drains to the bus in the background.
- Reads go to the bus and complete when the bus returns data.
- Storage is a simple dual-port RAM: one registered read port, one write port.

Parameters:
- DEPTH, 4096: FIFO entries; power of two, >=2.
- STALL_READ, 0: 1 = a read waits until the FIFO is empty and the bus is idle (coherent). 0 = a read bypasses queued writes as soon as the bus is idle.

Ports:
- i_clock  in  1  sole clock, rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- o_empty  out  1  FIFO holds 0 entries.
- o_full  out  1  FIFO holds DEPTH entries.
- o_bus_rw  out  1  1=write, 0=read.
- o_bus_request  out  1  bus request, held until i_bus_ready.
- i_bus_ready  in  1  one-cycle bus completion pulse.
- o_bus_address  out  32  bus address.
- i_bus_rdata  in  32  bus read data, valid with i_bus_ready.
- o_bus_wdata  out  32  bus write data.
- i_rw  in  1  requester 1=write, 0=read.
- i_request  in  1  requester request, level, held until o_ready.
- o_ready  out  1  one-cycle completion pulse.
- i_address  in  32  requester address.
- o_rdata  out  32  read data, valid with o_ready.
- i_wdata  in  32  requester write data.

Behaviour:
- Reset (i_reset_n=0 at a clock edge):
  - Pointers and count cleared; o_empty=1, o_full=0.
  - o_bus_request=0, o_ready=0, o_rdata=0, o_bus_rw=0, o_bus_address=0, o_bus_wdata=0.
  - Both FSMs go to IDLE. An in-flight bus transaction is abandoned; bus ready pulses seen during or after reset are ignored.
- Requester handshake:
  - A request is accepted only when i_request=1 and the front end is in ACCEPT.
  - After pulsing o_ready the front end enters RELEASE and waits for i_request=0 before accepting again. This prevents double acceptance when the requester drops i_request one cycle after seeing ready.
- Write path:
  - When not full, push {i_address,i_wdata} and pulse o_ready on the next cycle (1-cycle latency).
  - When full, hold the request without acking until an entry drains, then push.
- Read path:
  - Wait for the bus to be idle. With STALL_READ=1, also wait until o_empty=1.
  - Drive o_bus_rw=0 with o_bus_address=i_address and hold o_bus_request.
  - On i_bus_ready: register o_rdata=i_bus_rdata, pulse o_ready the same cycle, drop the request.
  - A pending read has priority over starting a new drain write. It never preempts a write already on the bus.
- Drain FSM states: IDLE -> FETCH -> WRITE -> GAP -> IDLE.
  - IDLE -> FETCH: FIFO not empty and no read pending.
  - FETCH: RAM read of the head entry, 1-cycle latency.
  - WRITE: o_bus_request=1, o_bus_rw=1, address/data from the entry, held stable.
  - On i_bus_ready: pop the entry, drop the request, go to GAP.
  - GAP: request stays low for one cycle, then IDLE.
  - Read FSM: IDLE -> READ -> GAP, sharing the bus mux. Only one bus owner at a time.
- FIFO:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
  - A push and a pop in the same cycle leave the count unchanged.
  - o_full and o_empty are registered from the count.
  - A push while full is impossible by construction; a pop while empty is impossible.
- Queued writes reach the bus in FIFO order. Read data reflects the bus only; there is no forwarding from the queue.

Decomposition:
- Package vram_wb_pkg: entry typedef {addr[31:0], data[31:0]}; drain/front-end state enums; BUS_W=32 constant.
- Sub-module dual_port_ram:
  - Parameters WIDTH and SIZE.
  - Ports: read address/data, registered 1-cycle output; write enable/address/data.
  - No reset on the storage array.

Test Plan:
- Reset then write 0xA5A5A5A5 to 0x100 -> o_ready 1 cycle after request; bus write addr 0x100 data 0xA5A5A5A5 issued; o_empty returns to 1 after i_bus_ready.
- Eight writes 0x0..0x1C with bus ready delayed 5 cycles each -> every write acked within 1 cycle; bus writes appear in order; o_empty=0 until the last ready.
- DEPTH=4 with bus ready withheld: 5th write -> o_full=1 and no ack until one i_bus_ready; then ack and push.
- STALL_READ=1: 3 queued writes then read 0x40 -> bus read issued only after the 3 writes drain; o_rdata = bus rdata 0xDEADBEEF with o_ready.
- STALL_READ=0: same stimulus -> read issued after the in-flight write completes, before the remaining 2 writes.
- Request held high 1 cycle after o_ready -> no second push/ack; reset asserted mid bus write -> o_bus_request=0, o_empty=1 next cycle.
